hilo_mult_unit: RTL and testbench

HILO_MULT_UNIT -- requirements
Module: hilo_mult_unit

---
 rtl/hilo_mult_unit.sv | 107 ++++++++++
 tb/tb_hilo_mult_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_unit.sv
// Hi/Lo multiply unit: 64x64 -> 128-bit sequential shift-add multiplier
// with directly writable Hi and Lo result registers.
//
// state | meaning
// IDLE  | waiting; accepts MulStart and direct Hi/Lo writes
// CALC  | one multiplier bit per cycle, 64 cycles; writes discarded
// DONE  | one-cycle completion; Hi/Lo hold the product; accepts MulStart
module hilo_mult_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MulStart,
  input  logic        MulSigned,
  input  logic [63:0] OpA,
  input  logic [63:0] OpB,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic [63:0] WriteData,
  output logic [63:0] Hi_ReadData,
  output logic [63:0] Lo_ReadData,
  output logic        HiLo_Busy,
  output logic        MulDone
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [5:0]     cnt;
  logic [127:0]   mcand;
  logic [63:0]    mplier;
  logic           sign;
  logic [127:0]   acc;
  logic [63:0]    hi, lo;

  logic [63:0]    mag_a, mag_b;
  logic [127:0]   acc_sum, product;
  logic           accept, last;

  // -2^63 negates to itself, which is the correct unsigned magnitude
  assign mag_a   = (MulSigned && OpA[63]) ? (~OpA + 64'd1) : OpA;
  assign mag_b   = (MulSigned && OpB[63]) ? (~OpB + 64'd1) : OpB;
  assign acc_sum = acc + (mplier[0] ? mcand : 128'd0);
  assign product = sign ? (~acc_sum + 128'd1) : acc_sum;
  assign accept  = (state != CALC);
  assign last    = (state == CALC) && (cnt == 6'd63);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    HiLo_Busy = 1'b0;
    MulDone   = 1'b0;
    case (state)
      IDLE: if (MulStart) state_nxt = CALC;
      CALC: begin
        HiLo_Busy = 1'b1;
        if (cnt == 6'd63) state_nxt = DONE;
      end
      DONE: begin
        MulDone   = 1'b1;
        state_nxt = MulStart ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt    <= 6'd0;
      mcand  <= 128'd0;
      mplier <= 64'd0;
      sign   <= 1'b0;
      acc    <= 128'd0;
    end else if (accept && MulStart) begin
      cnt    <= 6'd0;
      mcand  <= {64'd0, mag_a};
      mplier <= mag_b;
      sign   <= MulSigned & (OpA[63] ^ OpB[63]);
      acc    <= 128'd0;
    end else if (state == CALC) begin
      cnt    <= cnt + 6'd1;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_sum;
    end
  end

  // The product wins over a direct write on the CALC-to-DONE edge
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hi <= 64'd0;
      lo <= 64'd0;
    end else if (last) begin
      hi <= product[127:64];
      lo <= product[63:0];
    end else if (accept) begin
      if (HiWrite) hi <= WriteData;
      if (LoWrite) lo <= WriteData;
    end
  end

  assign Hi_ReadData = hi;
  assign Lo_ReadData = lo;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit: directed corner products, random
// products against a 128-bit arithmetic model, writes, reset abort, chaining.
module tb_hilo_mult_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        MulStart = 1'b0;
  logic        MulSigned = 1'b0;
  logic [63:0] OpA = 64'd0;
  logic [63:0] OpB = 64'd0;
  logic        HiWrite = 1'b0;
  logic        LoWrite = 1'b0;
  logic [63:0] WriteData = 64'd0;
  logic [63:0] Hi_ReadData, Lo_ReadData;
  logic        HiLo_Busy, MulDone;

  int passed = 0;
  int total  = 0;

  hilo_mult_unit dut (
    .Clk(Clk), .Reset(Reset), .MulStart(MulStart), .MulSigned(MulSigned),
    .OpA(OpA), .OpB(OpB), .HiWrite(HiWrite), .LoWrite(LoWrite),
    .WriteData(WriteData), .Hi_ReadData(Hi_ReadData), .Lo_ReadData(Lo_ReadData),
    .HiLo_Busy(HiLo_Busy), .MulDone(MulDone)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Reference: extend operands to 128 bits and multiply modulo 2^128
  function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                            input logic s);
    logic [127:0] ea, eb;
    ea = s ? {{64{a[63]}}, a} : {64'd0, a};
    eb = s ? {{64{b[63]}}, b} : {64'd0, b};
    return ea * eb;
  endfunction

  task automatic start_mul(input logic [63:0] a, input logic [63:0] b, input logic s);
    OpA = a; OpB = b; MulSigned = s; MulStart = 1'b1;
    tick;
    MulStart  = 1'b0;
    OpA       = {$urandom(), $urandom()};
    OpB       = {$urandom(), $urandom()};
    MulSigned = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int n, output int busy_n);
    n = 0; busy_n = 0;
    while (MulDone !== 1'b1 && n < 200) begin
      if (HiLo_Busy === 1'b1) busy_n++;
      tick;
      n++;
    end
  endtask

  task automatic check_mul(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic s);
    int n, bn;
    logic [127:0] exp;
    exp = ref_prod(a, b, s);
    start_mul(a, b, s);
    wait_done(n, bn);
    total++; if (n !== 64) $display("FAIL %s latency: got %0d want 64", name, n); else passed++;
    total++; if (bn !== 64) $display("FAIL %s busy_cycles: got %0d want 64", name, bn); else passed++;
    total++; if (Hi_ReadData !== exp[127:64])
      $display("FAIL %s hi: got %h want %h", name, Hi_ReadData, exp[127:64]); else passed++;
    total++; if (Lo_ReadData !== exp[63:0])
      $display("FAIL %s lo: got %h want %h", name, Lo_ReadData, exp[63:0]); else passed++;
    tick;
    total++; if ({MulDone, HiLo_Busy} !== 2'b00)
      $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, MulDone, HiLo_Busy);
    else passed++;
  endtask

  task automatic test_reset;
    #1 Reset = 1'b1;
    #1;
    total++; if ({Hi_ReadData, Lo_ReadData} !== 128'd0)
      $display("FAIL reset hilo: got %h %h want 0 0", Hi_ReadData, Lo_ReadData); else passed++;
    total++; if ({MulDone, HiLo_Busy} !== 2'b00)
      $display("FAIL reset flags: got done=%b busy=%b want 0 0", MulDone, HiLo_Busy); else passed++;
    tick; tick;
    Reset = 1'b0;
  endtask

  task automatic test_directed;
    check_mul("u3x5", 64'd3, 64'd5, 1'b0);
    total++; if ({Hi_ReadData, Lo_ReadData} !== {64'd0, 64'd15})
      $display("FAIL u3x5_const: got %h %h want 0 f", Hi_ReadData, Lo_ReadData); else passed++;
    check_mul("sm2x3", 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1);
    total++; if ({Hi_ReadData, Lo_ReadData} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA})
      $display("FAIL sm2x3_const: got %h %h", Hi_ReadData, Lo_ReadData); else passed++;
    check_mul("umax", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    total++; if ({Hi_ReadData, Lo_ReadData} !== {64'hFFFF_FFFF_FFFF_FFFE, 64'd1})
      $display("FAIL umax_const: got %h %h", Hi_ReadData, Lo_ReadData); else passed++;
    check_mul("smin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    total++; if ({Hi_ReadData, Lo_ReadData} !== {64'h4000_0000_0000_0000, 64'd0})
      $display("FAIL smin_const: got %h %h", Hi_ReadData, Lo_ReadData); else passed++;
    check_mul("sminx1", 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    check_mul("zero", 64'd0, 64'hDEAD_BEEF_0000_1234, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      logic [63:0] a, b;
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      if (i % 4 == 1) a[63] = 1'b1;
      if (i % 4 == 2) b = {32'hFFFF_FFFF, $urandom()};
      check_mul($sformatf("rand%0d", i), a, b, 1'(i % 2));
    end
  endtask

  task automatic test_direct_write;
    int n, bn;
    logic [127:0] exp;
    WriteData = 64'hAAAA_5555_0000_1111; HiWrite = 1'b1; tick; HiWrite = 1'b0;
    total++; if (Hi_ReadData !== 64'hAAAA_5555_0000_1111)
      $display("FAIL mthi: got %h want aaaa555500001111", Hi_ReadData); else passed++;
    WriteData = 64'h0123_4567_89AB_CDEF; LoWrite = 1'b1; tick; LoWrite = 1'b0;
    total++; if ({Hi_ReadData, Lo_ReadData} !== {64'hAAAA_5555_0000_1111, 64'h0123_4567_89AB_CDEF})
      $display("FAIL mtlo: got %h %h", Hi_ReadData, Lo_ReadData); else passed++;
    WriteData = 64'h5A5A_5A5A_5A5A_5A5A; HiWrite = 1'b1; LoWrite = 1'b1;
    exp = ref_prod(64'd1000, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
    start_mul(64'd1000, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
    HiWrite = 1'b0; LoWrite = 1'b0;
    total++; if ({Hi_ReadData, Lo_ReadData} !== {2{64'h5A5A_5A5A_5A5A_5A5A}})
      $display("FAIL write_with_start: got %h %h want 5a5a.. 5a5a..", Hi_ReadData, Lo_ReadData);
    else passed++;
    wait_done(n, bn);
    total++; if ({Hi_ReadData, Lo_ReadData} !== exp)
      $display("FAIL write_then_product: got %h %h want %h", Hi_ReadData, Lo_ReadData, exp);
    else passed++;
    tick;
  endtask

  task automatic test_write_during_calc;
    int n, bn;
    start_mul(64'd3, 64'd5, 1'b0);
    repeat (10) tick;
    WriteData = 64'h1234; LoWrite = 1'b1; HiWrite = 1'b1;
    repeat (5) tick;
    total++; if (Lo_ReadData === 64'h1234)
      $display("FAIL calc_write_mid: got %h want not 1234", Lo_ReadData); else passed++;
    wait_done(n, bn);
    LoWrite = 1'b0; HiWrite = 1'b0;
    total++; if ({Hi_ReadData, Lo_ReadData} !== {64'd0, 64'd15})
      $display("FAIL calc_write_product: got %h %h want 0 f", Hi_ReadData, Lo_ReadData); else passed++;
    tick;
  endtask

  task automatic test_reset_mid_calc;
    int n, bn, seen;
    logic [127:0] exp;
    start_mul(64'h1111_2222_3333_4444, 64'h0000_0000_0055_6677, 1'b0);
    repeat (29) tick;
    Reset = 1'b1;
    #1;
    total++; if ({MulDone, HiLo_Busy} !== 2'b00)
      $display("FAIL abort_flags: got done=%b busy=%b want 0 0", MulDone, HiLo_Busy); else passed++;
    total++; if ({Hi_ReadData, Lo_ReadData} !== 128'd0)
      $display("FAIL abort_hilo: got %h %h want 0 0", Hi_ReadData, Lo_ReadData); else passed++;
    tick;
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (MulDone === 1'b1 || HiLo_Busy === 1'b1) seen++;
      tick;
    end
    total++; if (seen !== 0 || {Hi_ReadData, Lo_ReadData} !== 128'd0)
      $display("FAIL abort_no_result: got activity=%0d hilo=%h %h want 0", seen,
               Hi_ReadData, Lo_ReadData); else passed++;
    Reset = 1'b1; #2; tick; Reset = 1'b0;
    exp = ref_prod(64'd7, 64'd9, 1'b0);
    start_mul(64'd7, 64'd9, 1'b0);
    total++; if (HiLo_Busy !== 1'b1)
      $display("FAIL first_edge_start: got busy=%b want 1", HiLo_Busy); else passed++;
    wait_done(n, bn);
    total++; if (n !== 64 || {Hi_ReadData, Lo_ReadData} !== exp)
      $display("FAIL post_reset_mul: got n=%0d %h %h want 64 %h", n, Hi_ReadData, Lo_ReadData, exp);
    else passed++;
    tick;
  endtask

  task automatic test_back_to_back;
    int n, bn;
    logic [127:0] e1, e2;
    e1 = ref_prod(64'hFFFF_FFFF_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    e2 = ref_prod(64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0);
    start_mul(64'hFFFF_FFFF_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done(n, bn);
    total++; if ({Hi_ReadData, Lo_ReadData} !== e1)
      $display("FAIL b2b_first: got %h %h want %h", Hi_ReadData, Lo_ReadData, e1); else passed++;
    start_mul(64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0);
    total++; if ({MulDone, HiLo_Busy} !== 2'b01)
      $display("FAIL b2b_no_idle: got done=%b busy=%b want 0 1", MulDone, HiLo_Busy); else passed++;
    wait_done(n, bn);
    total++; if (n !== 64 || bn !== 64)
      $display("FAIL b2b_latency: got %0d/%0d want 64/64", n, bn); else passed++;
    total++; if ({Hi_ReadData, Lo_ReadData} !== e2)
      $display("FAIL b2b_second: got %h %h want %h", Hi_ReadData, Lo_ReadData, e2); else passed++;
    tick;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_direct_write;
    test_write_during_calc;
    test_reset_mid_calc;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
